// File: rtl/bcd_pkg.sv
// Shared types and helpers for the priority-to-BCD encoder.
// Holds the FSM state enum, the BCD digit type and the double-dabble digit correction.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // Minimum number of decimal digits needed to represent n.
    function automatic int unsigned bcd_digits_for(input int unsigned n);
        int unsigned digits;
        int unsigned limit;
        digits = 1;
        limit  = 10;
        while (limit <= n) begin
            digits = digits + 1;
            limit  = limit * 10;
        end
        return digits;
    endfunction

    function automatic bcd_digit_t add3_if_ge5(input bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/prio_index_find.sv
// Combinational priority search over a [N_IN:1] request vector.
// Reports the winning index (0 when empty), an empty flag and a more-than-one-set flag.
module prio_index_find #(
    parameter int unsigned N_IN          = 99,
    parameter bit          PRIORITY_HIGH = 1'b1,
    parameter int unsigned IDX_W         = $clog2(N_IN + 1)
) (
    input  logic [N_IN:1]    req,
    output logic [IDX_W-1:0] idx,
    output logic             none,
    output logic             multi
);

    logic seen;

    // Ascending scan: the high-priority variant keeps overwriting with the latest hit,
    // the low-priority variant only takes the first hit.
    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 1; i <= N_IN; i++) begin
            if (req[i]) begin
                if (PRIORITY_HIGH || !seen) begin
                    idx = IDX_W'(i);
                end
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        none = ~seen;
    end

endmodule

// File: rtl/prio_bcd_encoder.sv
// Priority encoder with an iterative double-dabble BCD converter and valid/ready on both sides.
// One accept per IDLE visit; the result is held in DONE until the consumer takes it.
module prio_bcd_encoder
    import bcd_pkg::*;
#(
    parameter int unsigned N_IN          = 99,
    parameter int unsigned NUM_DIGITS    = 2,
    parameter bit          PRIORITY_HIGH = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [N_IN:1]           decimal_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_DIGITS*4-1:0] bcd_out,
    output logic                    none_set,
    output logic                    multi_hot,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned IDX_W = $clog2(N_IN + 1);
    localparam int unsigned BCD_W = NUM_DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(IDX_W + 1);

    if (N_IN < 1 || N_IN > 9999) begin : g_bad_n_in
        $error("N_IN must lie in 1..9999");
    end
    if (NUM_DIGITS < bcd_digits_for(N_IN)) begin : g_bad_digits
        $error("NUM_DIGITS too small to hold N_IN in BCD");
    end

    state_t             state_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX_W-1:0]   pf_idx;
    logic               pf_none;
    logic               pf_multi;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;

    prio_index_find #(
        .N_IN          (N_IN),
        .PRIORITY_HIGH (PRIORITY_HIGH),
        .IDX_W         (IDX_W)
    ) u_find (
        .req   (decimal_in),
        .idx   (pf_idx),
        .none  (pf_none),
        .multi (pf_multi)
    );

    // One double-dabble step: correct every digit, then shift in the next index MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            bcd_adj[d*4 +: 4] = add3_if_ge5(bcd_q[d*4 +: 4]);
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], idx_q[IDX_W-1]};
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            bcd_out   <= '0;
            none_set  <= 1'b0;
            multi_hot <= 1'b0;
            bcd_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        idx_q     <= pf_idx;
                        bcd_q     <= '0;
                        none_set  <= pf_none;
                        multi_hot <= pf_multi;
                        cnt_q     <= CNT_W'(IDX_W);
                        in_ready  <= 1'b0;
                        state_q   <= CONVERT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CONVERT: begin
                    bcd_q <= bcd_shift;
                    idx_q <= idx_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_out   <= bcd_shift;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
